mmio_arb2: RTL and testbench
============================

MMIO_ARB2 -- requirements
Module: mmio_arb2

Interface
REQ-001 Parameter W_OFFSET, default 30: width of the register offset on both requester ports and the target port.
REQ-002 Parameter W_DATA, default 32: width of the write and read data on all ports.
REQ-003 Port CLK  in  1: single clock; all state changes on its rising edge.
REQ-004 Port RST_X  in  1: asynchronous, active-low reset.
REQ-005 Ports w_mN_req  in  1 (N=0,1): requester N has a command pending; held high, with the command fields stable, until w_mN_ack.
REQ-006 Ports w_mN_we  in  1: 1 = write, 0 = read.
REQ-007 Ports w_mN_offset  in  W_OFFSET: target register offset.
REQ-008 Ports w_mN_wdata  in  W_DATA: write data.
REQ-009 Ports w_mN_ack  out  1: one-cycle pulse; the command is accepted.
REQ-010 Ports w_mN_rvalid  out  1: one-cycle pulse; the transaction is complete.
REQ-011 Ports w_mN_rdata  out  W_DATA: read data, valid while w_mN_rvalid is high.
REQ-012 Port w_offset  out  W_OFFSET: target offset.
REQ-013 Port w_we  out  1: target write strobe.
REQ-014 Port w_wdata  out  W_DATA: target write data.
REQ-015 Port w_re  out  1: target read strobe; has side effects (interrupt claim).
REQ-016 Port w_rdata  in  W_DATA: target read data; registered by the target one cycle after w_offset is presented.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE and WAIT, with all outputs driven from registers.
REQ-018 IDLE: if any w_mN_req is high, select a winner per REQ-025, latch its we/offset/wdata and go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE (exactly one cycle):
- w_offset and w_wdata = the latched values.
- w_we = latched we; w_re = !latched we.
- w_mN_ack = 1 for the winner only.
- Next state: WAIT.
REQ-020 WAIT (exactly one cycle):
- w_offset held; w_we = w_re = 0.
- At the end of the cycle, capture w_rdata (reads) or 0 (writes) into w_mN_rdata of the winner and go to IDLE.
REQ-021 In the IDLE cycle following WAIT, w_mN_rvalid SHALL pulse for the winner; a new request may be selected in that same cycle.
REQ-022 Latency: request seen in cycle 0 -> ack in cycle 1 -> rvalid in cycle 3; back-to-back issue spacing is 3 cycles.
REQ-023 w_re and w_we SHALL each be asserted for exactly one cycle per transaction and never together.
REQ-024 While not in ISSUE:
- w_we and w_re = 0.
- w_offset and w_wdata hold their last value (0 after reset).
REQ-025 Arbitration when both w_mN_req are high in IDLE SHALL follow REQ-031; when a single request is high, that requester wins.
REQ-026 w_mN_rdata SHALL hold its value until that requester's next completion.
REQ-027 A request deasserted before its ack is a protocol violation; the latched command still completes.

Reset
REQ-028 RST_X low SHALL immediately force the following, independent of CLK:
- State = IDLE.
- All outputs = 0, including w_mN_rdata.
- Latched command = 0.
- Round-robin pointer = "last granted = m1".
REQ-029 Reset asserted in ISSUE or WAIT SHALL abort the transaction: no ack or rvalid pulse after reset release.
REQ-030 The first rising CLK edge with RST_X high SHALL evaluate IDLE normally.

Configuration
REQ-031 Macro MMIO_ARB_RR_EN:
- Defined: round-robin; on simultaneous requests the requester not granted last wins, and the pointer updates on every grant.
- Undefined: fixed priority; m0 always wins and no pointer register exists.

Verification
REQ-032 Read: m0 requests offset 0x200004 while the target returns 0x5 -> w_re is high for one cycle, w_m0_ack is in cycle 1, w_m0_rvalid is in cycle 3, and w_m0_rdata = 0x5.
REQ-033 Write: m1 writes 0x7 to 0x4 -> w_we is high for one cycle with w_offset = 0x4 and w_wdata = 0x7, then w_m1_rvalid pulses with w_m1_rdata = 0.
REQ-034 Simultaneous requests, held continuously, with MMIO_ARB_RR_EN defined -> grants alternate m0, m1, m0, m1 at 3-cycle spacing; with the macro undefined -> m0 is granted every time and m1 is starved.
REQ-035 RST_X is driven low during WAIT of an m0 read -> outputs go to 0 without a clock edge, and no w_m0_rvalid pulse follows after release.
REQ-036 Randomized back-to-back traffic -> w_we & w_re are never high together, each ack has exactly one matching rvalid, and w_re pulses exactly once per read.

Source files
------------

// File: rtl/mmio_arb2.sv
// mmio_arb2: arbitrates two MMIO requesters onto one target port whose read data returns one cycle after the offset.
// Define MMIO_ARB_RR_EN for round-robin arbitration; when it is undefined, m0 has fixed priority.
module mmio_arb2 #(
   parameter int W_OFFSET = 30,
   parameter int W_DATA   = 32
) (
   input  logic                CLK,
   input  logic                RST_X,
   input  logic                w_m0_req,
   input  logic                w_m0_we,
   input  logic [W_OFFSET-1:0] w_m0_offset,
   input  logic [W_DATA-1:0]   w_m0_wdata,
   output logic                w_m0_ack,
   output logic                w_m0_rvalid,
   output logic [W_DATA-1:0]   w_m0_rdata,
   input  logic                w_m1_req,
   input  logic                w_m1_we,
   input  logic [W_OFFSET-1:0] w_m1_offset,
   input  logic [W_DATA-1:0]   w_m1_wdata,
   output logic                w_m1_ack,
   output logic                w_m1_rvalid,
   output logic [W_DATA-1:0]   w_m1_rdata,
   output logic [W_OFFSET-1:0] w_offset,
   output logic                w_we,
   output logic [W_DATA-1:0]   w_wdata,
   output logic                w_re,
   input  logic [W_DATA-1:0]   w_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                state_r;
   logic                  winner_r;
   logic                  cmd_we_r;
   logic                  req_any_s;
   logic                  grant_s;
   logic                  sel_we_s;
   logic [W_OFFSET-1:0]   sel_offset_s;
   logic [W_DATA-1:0]     sel_wdata_s;
`ifdef MMIO_ARB_RR_EN
   logic                  last_r;
`endif

   // Winner selection and command mux for the IDLE decision
   always_comb begin
      req_any_s = w_m0_req | w_m1_req;
      grant_s   = 1'b0;
`ifdef MMIO_ARB_RR_EN
      // on a tie the requester that was not granted last wins
      if (w_m0_req && w_m1_req) begin
         grant_s = ~last_r;
      end else begin
         grant_s = ~w_m0_req;
      end
`else
      grant_s = ~w_m0_req;
`endif
      if (grant_s) begin
         sel_we_s     = w_m1_we;
         sel_offset_s = w_m1_offset;
         sel_wdata_s  = w_m1_wdata;
      end else begin
         sel_we_s     = w_m0_we;
         sel_offset_s = w_m0_offset;
         sel_wdata_s  = w_m0_wdata;
      end
   end

   // FSM with all requester and target outputs registered
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state_r     <= IDLE;
         winner_r    <= 1'b0;
         cmd_we_r    <= 1'b0;
         w_offset    <= {W_OFFSET{1'b0}};
         w_wdata     <= {W_DATA{1'b0}};
         w_we        <= 1'b0;
         w_re        <= 1'b0;
         w_m0_ack    <= 1'b0;
         w_m1_ack    <= 1'b0;
         w_m0_rvalid <= 1'b0;
         w_m1_rvalid <= 1'b0;
         w_m0_rdata  <= {W_DATA{1'b0}};
         w_m1_rdata  <= {W_DATA{1'b0}};
`ifdef MMIO_ARB_RR_EN
         last_r      <= 1'b1;
`endif
      end else begin
         w_we        <= 1'b0;
         w_re        <= 1'b0;
         w_m0_ack    <= 1'b0;
         w_m1_ack    <= 1'b0;
         w_m0_rvalid <= 1'b0;
         w_m1_rvalid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_any_s) begin
                  winner_r <= grant_s;
                  cmd_we_r <= sel_we_s;
                  // w_offset / w_wdata double as the latched command and hold until the next grant
                  w_offset <= sel_offset_s;
                  w_wdata  <= sel_wdata_s;
                  w_we     <= sel_we_s;
                  w_re     <= ~sel_we_s;
                  w_m0_ack <= ~grant_s;
                  w_m1_ack <= grant_s;
`ifdef MMIO_ARB_RR_EN
                  last_r   <= grant_s;
`endif
                  state_r  <= ISSUE;
               end else begin
                  state_r  <= IDLE;
               end
            end
            ISSUE: begin
               state_r <= WAIT;
            end
            WAIT: begin
               if (winner_r) begin
                  w_m1_rdata  <= cmd_we_r ? {W_DATA{1'b0}} : w_rdata;
                  w_m1_rvalid <= 1'b1;
               end else begin
                  w_m0_rdata  <= cmd_we_r ? {W_DATA{1'b0}} : w_rdata;
                  w_m0_rvalid <= 1'b1;
               end
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_arb2.sv
// Self-checking bench for mmio_arb2: directed read/write/arbitration/reset scenarios plus
// randomized traffic against a transaction-level model of grants and completions.
module tb_mmio_arb2;
   localparam int W_OFFSET = 30;
   localparam int W_DATA   = 32;
`ifdef MMIO_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic                CLK = 1'b0;
   logic                RST_X;
   logic                w_m0_req, w_m0_we, w_m0_ack, w_m0_rvalid;
   logic [W_OFFSET-1:0] w_m0_offset;
   logic [W_DATA-1:0]   w_m0_wdata, w_m0_rdata;
   logic                w_m1_req, w_m1_we, w_m1_ack, w_m1_rvalid;
   logic [W_OFFSET-1:0] w_m1_offset;
   logic [W_DATA-1:0]   w_m1_wdata, w_m1_rdata;
   logic [W_OFFSET-1:0] w_offset;
   logic                w_we, w_re;
   logic [W_DATA-1:0]   w_wdata;
   logic [W_DATA-1:0]   w_rdata = 32'h0;

   int n_tests = 0;
   int n_fail  = 0;
   int mdl_last = 1;

   mmio_arb2 #(.W_OFFSET(W_OFFSET), .W_DATA(W_DATA)) dut (
      .CLK(CLK), .RST_X(RST_X),
      .w_m0_req(w_m0_req), .w_m0_we(w_m0_we), .w_m0_offset(w_m0_offset), .w_m0_wdata(w_m0_wdata),
      .w_m0_ack(w_m0_ack), .w_m0_rvalid(w_m0_rvalid), .w_m0_rdata(w_m0_rdata),
      .w_m1_req(w_m1_req), .w_m1_we(w_m1_we), .w_m1_offset(w_m1_offset), .w_m1_wdata(w_m1_wdata),
      .w_m1_ack(w_m1_ack), .w_m1_rvalid(w_m1_rvalid), .w_m1_rdata(w_m1_rdata),
      .w_offset(w_offset), .w_we(w_we), .w_wdata(w_wdata), .w_re(w_re), .w_rdata(w_rdata)
   );

   always #5 CLK = ~CLK;

   function automatic logic [W_DATA-1:0] tgt_data(input logic [W_OFFSET-1:0] off);
      if (off == 30'h0200004) return 32'h5;
      return {2'b00, off} ^ 32'hC3C3_0000;
   endfunction

   // target model: read data registered one cycle after the offset
   always @(posedge CLK) w_rdata <= tgt_data(w_offset);

   // arbitration rule: lone requester wins; tie goes to m0 (fixed) or the one not granted last (RR)
   function automatic int pick(input logic r0, input logic r1);
      if (r0 && r1) return RR ? ((mdl_last == 1) ? 0 : 1) : 0;
      if (r0) return 0;
      return 1;
   endfunction

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs;
      w_m0_req = 1'b0; w_m0_we = 1'b0; w_m0_offset = '0; w_m0_wdata = '0;
      w_m1_req = 1'b0; w_m1_we = 1'b0; w_m1_offset = '0; w_m1_wdata = '0;
   endtask

   task automatic test_reset;
      logic [W_OFFSET+4*W_DATA+5:0] all_out;
      clear_inputs();
      RST_X = 1'b0;
      repeat (3) tick();
      all_out = {w_m0_ack, w_m0_rvalid, w_m0_rdata, w_m1_ack, w_m1_rvalid, w_m1_rdata,
                 w_offset, w_we, w_wdata, w_re};
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      RST_X = 1'b1;
      mdl_last = 1;
      tick();
      all_out = {w_m0_ack, w_m0_rvalid, w_m0_rdata, w_m1_ack, w_m1_rvalid, w_m1_rdata,
                 w_offset, w_we, w_wdata, w_re};
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL idle_after_release: got %h expected 0", all_out);
      end
   endtask

   task automatic test_read;
      int re_cnt = 0;
      w_m0_req = 1'b1; w_m0_we = 1'b0; w_m0_offset = 30'h0200004; w_m0_wdata = $urandom;
      tick(); // cycle 1
      re_cnt += int'(w_re);
      n_tests++;
      if ({w_m0_ack, w_m1_ack, w_re, w_we} !== 4'b1010) begin
         n_fail++; $display("FAIL read_issue: got %b expected 1010", {w_m0_ack, w_m1_ack, w_re, w_we});
      end
      n_tests++;
      if (w_offset !== 30'h0200004) begin
         n_fail++; $display("FAIL read_offset: got %h expected 0200004", w_offset);
      end
      w_m0_req = 1'b0;
      mdl_last = 0;
      tick(); // cycle 2
      re_cnt += int'(w_re);
      n_tests++;
      if ({w_m0_ack, w_re, w_we, w_m0_rvalid, w_offset} !== {4'b0000, 30'h0200004}) begin
         n_fail++; $display("FAIL read_wait: got %b/%h expected 0000/0200004",
                            {w_m0_ack, w_re, w_we, w_m0_rvalid}, w_offset);
      end
      tick(); // cycle 3
      re_cnt += int'(w_re);
      n_tests++;
      if ({w_m0_rvalid, w_m1_rvalid, w_m0_rdata} !== {2'b10, 32'h5}) begin
         n_fail++; $display("FAIL read_rvalid: got %b/%h expected 10/5", {w_m0_rvalid, w_m1_rvalid}, w_m0_rdata);
      end
      tick(); // cycle 4
      re_cnt += int'(w_re);
      n_tests++;
      if ({w_m0_rvalid, w_m0_rdata} !== {1'b0, 32'h5}) begin
         n_fail++; $display("FAIL read_hold: got %b/%h expected 0/5", w_m0_rvalid, w_m0_rdata);
      end
      n_tests++;
      if (re_cnt !== 1) begin
         n_fail++; $display("FAIL read_re_count: got %0d expected 1", re_cnt);
      end
   endtask

   task automatic test_write;
      w_m1_req = 1'b1; w_m1_we = 1'b1; w_m1_offset = 30'h4; w_m1_wdata = 32'h7;
      tick(); // cycle 1
      n_tests++;
      if ({w_m0_ack, w_m1_ack, w_we, w_re, w_offset, w_wdata} !== {4'b0110, 30'h4, 32'h7}) begin
         n_fail++; $display("FAIL write_issue: got %b/%h/%h expected 0110/4/7",
                            {w_m0_ack, w_m1_ack, w_we, w_re}, w_offset, w_wdata);
      end
      w_m1_req = 1'b0;
      mdl_last = 1;
      tick(); // cycle 2
      n_tests++;
      if ({w_m1_ack, w_we, w_re, w_m1_rvalid} !== 4'b0000) begin
         n_fail++; $display("FAIL write_wait: got %b expected 0000", {w_m1_ack, w_we, w_re, w_m1_rvalid});
      end
      tick(); // cycle 3
      n_tests++;
      if ({w_m0_rvalid, w_m1_rvalid, w_m1_rdata, w_m0_rdata} !== {2'b01, 32'h0, 32'h5}) begin
         n_fail++; $display("FAIL write_rvalid: got %b/%h/%h expected 01/0/5",
                            {w_m0_rvalid, w_m1_rvalid}, w_m1_rdata, w_m0_rdata);
      end
      tick();
   endtask

   task automatic test_simultaneous;
      int who;
      int m1_grants = 0;
      int exp_m1_grants = 0;
      logic [3:0] exp_v;
      logic [W_OFFSET-1:0] offs [2];
      offs[0] = 30'h10; offs[1] = 30'h20;
      w_m0_req = 1'b1; w_m0_we = 1'b0; w_m0_offset = offs[0];
      w_m1_req = 1'b1; w_m1_we = 1'b0; w_m1_offset = offs[1];
      who = pick(1'b1, 1'b1);
      mdl_last = who;
      exp_m1_grants += who;
      for (int c = 1; c <= 12; c++) begin
         tick();
         exp_v = {(c % 3 == 1) && who == 0, (c % 3 == 1) && who == 1,
                  (c % 3 == 0) && who == 0, (c % 3 == 0) && who == 1};
         m1_grants += int'(w_m1_ack);
         n_tests++;
         if ({w_m0_ack, w_m1_ack, w_m0_rvalid, w_m1_rvalid} !== exp_v) begin
            n_fail++; $display("FAIL simul_cycle%0d: got %b expected %b", c,
                               {w_m0_ack, w_m1_ack, w_m0_rvalid, w_m1_rvalid}, exp_v);
         end
         if (c % 3 == 0) begin
            n_tests++;
            if ((who == 0 ? w_m0_rdata : w_m1_rdata) !== tgt_data(offs[who])) begin
               n_fail++; $display("FAIL simul_rdata%0d: got %h expected %h", c,
                                  (who == 0 ? w_m0_rdata : w_m1_rdata), tgt_data(offs[who]));
            end
            if (c < 12) begin
               who = pick(1'b1, 1'b1);
               mdl_last = who;
               if (c < 10) exp_m1_grants += who;
            end
         end
      end
      clear_inputs();
      n_tests++;
      if (m1_grants !== exp_m1_grants) begin
         n_fail++; $display("FAIL simul_m1_grants: got %0d expected %0d", m1_grants, exp_m1_grants);
      end
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset_in_wait;
      logic [W_OFFSET+4*W_DATA+5:0] all_out;
      w_m0_req = 1'b1; w_m0_we = 1'b0; w_m0_offset = 30'h30;
      tick(); // cycle 1
      n_tests++;
      if (w_m0_ack !== 1'b1) begin
         n_fail++; $display("FAIL rstwait_ack: got %b expected 1", w_m0_ack);
      end
      w_m0_req = 1'b0;
      tick(); // cycle 2 (WAIT)
      #2;
      RST_X = 1'b0;
      #1;
      all_out = {w_m0_ack, w_m0_rvalid, w_m0_rdata, w_m1_ack, w_m1_rvalid, w_m1_rdata,
                 w_offset, w_we, w_wdata, w_re};
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL rstwait_async_clear: got %h expected 0", all_out);
      end
      tick();
      RST_X = 1'b1;
      mdl_last = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_tests++;
         if ({w_m0_ack, w_m1_ack, w_m0_rvalid, w_m1_rvalid, w_we, w_re} !== 6'b0) begin
            n_fail++; $display("FAIL rstwait_no_pulse%0d: got %b expected 000000", c,
                               {w_m0_ack, w_m1_ack, w_m0_rvalid, w_m1_rvalid, w_we, w_re});
         end
      end
   endtask

   task automatic test_random;
      int ack_t = -10, rv_t = -10, free_t = 0, who = 0;
      int n_ack = 0, n_rv = 0, n_re = 0, n_reads = 0, n_grants = 0;
      logic cmd_we = 1'b0;
      logic [W_OFFSET-1:0] cmd_off = '0;
      logic [W_DATA-1:0] cmd_wd = '0;
      logic [W_OFFSET-1:0] exp_off;
      logic [W_DATA-1:0] exp_wd;
      logic [W_DATA-1:0] exp_rd [2];
      logic r_req [2];
      logic r_we [2];
      logic [W_OFFSET-1:0] r_off [2];
      logic [W_DATA-1:0] r_wd [2];
      logic [5:0] exp_v;
      // state left by the preceding reset
      exp_off = '0; exp_wd = '0; exp_rd[0] = '0; exp_rd[1] = '0;
      for (int n = 0; n < 2; n++) begin
         r_req[n] = 1'b0; r_we[n] = 1'b0; r_off[n] = '0; r_wd[n] = '0;
      end
      clear_inputs();
      for (int t = 1; t <= 400; t++) begin
         tick();
         exp_v = {t == ack_t && who == 0, t == ack_t && who == 1, t == rv_t && who == 0,
                  t == rv_t && who == 1, t == ack_t && cmd_we, t == ack_t && !cmd_we};
         if (t == ack_t) begin
            exp_off = cmd_off;
            exp_wd  = cmd_wd;
         end
         if (t == rv_t) exp_rd[who] = cmd_we ? 32'h0 : tgt_data(cmd_off);
         n_tests++;
         if ({w_m0_ack, w_m1_ack, w_m0_rvalid, w_m1_rvalid, w_we, w_re} !== exp_v) begin
            n_fail++; $display("FAIL rand_ctl t=%0d: got %b expected %b", t,
                               {w_m0_ack, w_m1_ack, w_m0_rvalid, w_m1_rvalid, w_we, w_re}, exp_v);
         end
         n_tests++;
         if ({w_offset, w_wdata} !== {exp_off, exp_wd}) begin
            n_fail++; $display("FAIL rand_target t=%0d: got %h/%h expected %h/%h", t,
                               w_offset, w_wdata, exp_off, exp_wd);
         end
         n_tests++;
         if ({w_m0_rdata, w_m1_rdata} !== {exp_rd[0], exp_rd[1]}) begin
            n_fail++; $display("FAIL rand_rdata t=%0d: got %h/%h expected %h/%h", t,
                               w_m0_rdata, w_m1_rdata, exp_rd[0], exp_rd[1]);
         end
         n_tests++;
         if ((w_we & w_re) !== 1'b0) begin
            n_fail++; $display("FAIL rand_we_re_overlap t=%0d: got 1 expected 0", t);
         end
         n_ack += int'(w_m0_ack) + int'(w_m1_ack);
         n_rv  += int'(w_m0_rvalid) + int'(w_m1_rvalid);
         n_re  += int'(w_re);
         // requesters: drop on ack, maybe raise a fresh command right away
         if (t == ack_t) r_req[who] = 1'b0;
         for (int n = 0; n < 2; n++) begin
            if (!r_req[n] && t <= 370 && $urandom_range(0, 1) == 1) begin
               r_req[n] = 1'b1;
               r_we[n]  = ($urandom_range(0, 1) == 1);
               r_off[n] = W_OFFSET'($urandom);
               r_wd[n]  = $urandom;
            end
         end
         w_m0_req = r_req[0]; w_m0_we = r_we[0]; w_m0_offset = r_off[0]; w_m0_wdata = r_wd[0];
         w_m1_req = r_req[1]; w_m1_we = r_we[1]; w_m1_offset = r_off[1]; w_m1_wdata = r_wd[1];
         if (t >= free_t && (r_req[0] || r_req[1])) begin
            who = pick(r_req[0], r_req[1]);
            mdl_last = who;
            cmd_we = r_we[who]; cmd_off = r_off[who]; cmd_wd = r_wd[who];
            ack_t = t + 1; rv_t = t + 3; free_t = t + 3;
            n_grants++;
            if (!cmd_we) n_reads++;
         end
      end
      clear_inputs();
      n_tests++;
      if (n_ack !== n_grants || n_rv !== n_grants) begin
         n_fail++; $display("FAIL rand_ack_rvalid_count: got ack=%0d rvalid=%0d expected %0d",
                            n_ack, n_rv, n_grants);
      end
      n_tests++;
      if (n_re !== n_reads) begin
         n_fail++; $display("FAIL rand_re_count: got %0d expected %0d", n_re, n_reads);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_simultaneous();
      test_reset_in_wait();
      test_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
